divisor_8x8: RTL and testbench

- Sequential unsigned 8-bit divider for the RPN ALU; the inverse operation of the repeated-addition multiplier.
- Divides dividend A by divisor B by repeated subtraction, one subtraction per clock.
- Produces quotient, remainder, divide-by-zero flag and a level Pronto handshake.
- Sits beside the multiplier in the ALU operation datapath and uses the same START/Pronto protocol.

---
 rtl/divisor_8x8_pkg.sv | 12 +
 rtl/divisor_8x8_if.sv | 18 +
 rtl/divisor_8x8_subtrator.sv | 24 ++
 rtl/divisor_8x8.sv | 132 +++++++++++++
 tb/tb_divisor_8x8.sv | 139 +++++++++++++
 5 files changed

// File: rtl/divisor_8x8_pkg.sv
// Shared constants for the RPN ALU sequential divider.
package divisor_8x8_pkg;

  localparam int unsigned LARGURA = 8;

  localparam logic [1:0] EST_IDLE = 2'b00;
  localparam logic [1:0] EST_CALC = 2'b01;
  localparam logic [1:0] EST_DONE = 2'b10;

  localparam logic [LARGURA-1:0] QUOC_SATURADO = 8'hFF;

endpackage

// File: rtl/divisor_8x8_if.sv
// START/Pronto operation bus between the ALU sequencer and the divider.
interface divisor_8x8_if;
  import divisor_8x8_pkg::*;

  logic               START;
  logic [LARGURA-1:0] A;
  logic [LARGURA-1:0] B;
  logic [LARGURA-1:0] Quociente;
  logic [LARGURA-1:0] Resto;
  logic               ErroDivZero;
  logic               Pronto;
  logic               Ocupado;

  modport master (output START, A, B,
                  input  Quociente, Resto, ErroDivZero, Pronto, Ocupado);
  modport slave  (input  START, A, B,
                  output Quociente, Resto, ErroDivZero, Pronto, Ocupado);
endinterface

// File: rtl/divisor_8x8_subtrator.sv
// Ripple-borrow subtractor; BorrowOut==0 means Minuendo >= Subtraendo.
module subtrator8x8
  import divisor_8x8_pkg::*;
(
  input  logic [LARGURA-1:0] Minuendo,
  input  logic [LARGURA-1:0] Subtraendo,
  output logic [LARGURA-1:0] Diferenca,
  output logic               BorrowOut
);

  logic [LARGURA:0] borrow;

  always_comb begin
    borrow[0] = 1'b0;
    Diferenca = '0;
    for (int i = 0; i < int'(LARGURA); i++) begin
      Diferenca[i]  = Minuendo[i] ^ Subtraendo[i] ^ borrow[i];
      borrow[i+1]   = (~Minuendo[i] & Subtraendo[i]) |
                      (~(Minuendo[i] ^ Subtraendo[i]) & borrow[i]);
    end
    BorrowOut = borrow[LARGURA];
  end

endmodule

// File: rtl/divisor_8x8.sv
// Sequential unsigned divider: repeated subtraction by default,
// restoring shift-subtract (one bit per cycle) when DIVISOR_RAPIDO_EN is defined.
module divisor_8x8
  import divisor_8x8_pkg::*;
(
  input  logic          CLOCK,
  input  logic          RESET,
  divisor_8x8_if.slave  bus
);

  logic [1:0]         estado,      estado_nxt;
  logic [LARGURA-1:0] divisor_reg, divisor_nxt;
  logic [LARGURA-1:0] resto_reg,   resto_nxt;
  logic [LARGURA-1:0] quoc_reg,    quoc_nxt;
  logic               erro_reg,    erro_nxt;
  logic               pronto_reg,  pronto_nxt;
  logic               ocupado_reg, ocupado_nxt;

  logic [LARGURA-1:0] sub_min;
  logic [LARGURA-1:0] sub_dif;
  logic               sub_borrow;

`ifdef DIVISOR_RAPIDO_EN
  localparam int unsigned CW = 4;
  logic [LARGURA-1:0] dvd_reg, dvd_nxt;
  logic [CW-1:0]      cnt_reg, cnt_nxt;
  logic [LARGURA-1:0] rem_in;
  logic               ge;

  // Partial remainder starts from zero on the first iteration; Resto holds A until then.
  assign rem_in  = (cnt_reg == '0) ? '0 : resto_reg;
  assign sub_min = {rem_in[LARGURA-2:0], dvd_reg[LARGURA-1]};
  assign ge      = rem_in[LARGURA-1] | ~sub_borrow;
`else
  assign sub_min = resto_reg;
`endif

  subtrator8x8 u_sub (
    .Minuendo   (sub_min),
    .Subtraendo (divisor_reg),
    .Diferenca  (sub_dif),
    .BorrowOut  (sub_borrow)
  );

  // Next-state and datapath update
  always_comb begin
    estado_nxt  = estado;
    divisor_nxt = divisor_reg;
    resto_nxt   = resto_reg;
    quoc_nxt    = quoc_reg;
    erro_nxt    = erro_reg;
`ifdef DIVISOR_RAPIDO_EN
    dvd_nxt     = dvd_reg;
    cnt_nxt     = cnt_reg;
`endif
    if (bus.START) begin
      divisor_nxt = bus.B;
      resto_nxt   = bus.A;
      quoc_nxt    = '0;
      erro_nxt    = 1'b0;
`ifdef DIVISOR_RAPIDO_EN
      dvd_nxt     = bus.A;
      cnt_nxt     = '0;
`endif
      if (bus.B == '0) begin
        estado_nxt = EST_DONE;
        quoc_nxt   = QUOC_SATURADO;
        erro_nxt   = 1'b1;
      end else begin
        estado_nxt = EST_CALC;
      end
    end else begin
      case (estado)
        EST_CALC: begin
`ifdef DIVISOR_RAPIDO_EN
          resto_nxt = ge ? sub_dif : sub_min;
          quoc_nxt  = {quoc_reg[LARGURA-2:0], ge};
          dvd_nxt   = {dvd_reg[LARGURA-2:0], 1'b0};
          cnt_nxt   = cnt_reg + CW'(1);
          if (cnt_reg == CW'(LARGURA - 1)) estado_nxt = EST_DONE;
`else
          if (!sub_borrow) begin
            resto_nxt = sub_dif;
            quoc_nxt  = quoc_reg + LARGURA'(1);
          end else begin
            estado_nxt = EST_DONE;
          end
`endif
        end
        EST_IDLE, EST_DONE: ;
        default: estado_nxt = EST_IDLE;
      endcase
    end
    pronto_nxt  = (estado_nxt == EST_DONE);
    ocupado_nxt = (estado_nxt == EST_CALC);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      estado      <= EST_IDLE;
      divisor_reg <= '0;
      resto_reg   <= '0;
      quoc_reg    <= '0;
      erro_reg    <= 1'b0;
      pronto_reg  <= 1'b0;
      ocupado_reg <= 1'b0;
`ifdef DIVISOR_RAPIDO_EN
      dvd_reg     <= '0;
      cnt_reg     <= '0;
`endif
    end else begin
      estado      <= estado_nxt;
      divisor_reg <= divisor_nxt;
      resto_reg   <= resto_nxt;
      quoc_reg    <= quoc_nxt;
      erro_reg    <= erro_nxt;
      pronto_reg  <= pronto_nxt;
      ocupado_reg <= ocupado_nxt;
`ifdef DIVISOR_RAPIDO_EN
      dvd_reg     <= dvd_nxt;
      cnt_reg     <= cnt_nxt;
`endif
    end
  end

  assign bus.Quociente   = quoc_reg;
  assign bus.Resto       = resto_reg;
  assign bus.ErroDivZero = erro_reg;
  assign bus.Pronto      = pronto_reg;
  assign bus.Ocupado     = ocupado_reg;

endmodule

// File: tb/tb_divisor_8x8.sv
// Directed testbench for divisor_8x8 (honours DIVISOR_RAPIDO_EN).
module tb_divisor_8x8;

  logic CLOCK;
  logic RESET;
  int   n_checks;
  int   n_errors;

  divisor_8x8_if bus ();

  divisor_8x8 dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int q, input bit bzero);
    if (bzero) return 0;
`ifdef DIVISOR_RAPIDO_EN
    return 8;
`else
    return q + 1;
`endif
  endfunction

  // Pulse START for one cycle; returns #1 after the sampling edge E0.
  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    @(negedge CLOCK);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge CLOCK);
    #1;
    bus.START = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int eq, input int er, input int ee);
    int lat;
    do_start(a, b);
    lat = 0;
    while (bus.Pronto !== 1'b1 && lat < 400) begin
      @(posedge CLOCK);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat(eq, b == 8'd0));
    check({tag, " quociente"}, int'(bus.Quociente), eq);
    check({tag, " resto"}, int'(bus.Resto), er);
    check({tag, " erro"}, int'(bus.ErroDivZero), ee);
    check({tag, " ocupado"}, int'(bus.Ocupado), 0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    CLOCK     = 1'b0;
    RESET     = 1'b1;
    bus.START = 1'b0;
    bus.A     = 8'd0;
    bus.B     = 8'd0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst quociente", int'(bus.Quociente), 0);
    check("rst resto", int'(bus.Resto), 0);
    check("rst pronto", int'(bus.Pronto), 0);
    check("rst ocupado", int'(bus.Ocupado), 0);
    check("rst erro", int'(bus.ErroDivZero), 0);
    @(negedge CLOCK);
    RESET = 1'b0;

    run_div("7/2", 8'd7, 8'd2, 3, 1, 0);
    // Results hold while inputs wander
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      bus.A = 8'(i * 37);
      bus.B = 8'(i * 11);
    end
    #1;
    check("7/2 hold q", int'(bus.Quociente), 3);
    check("7/2 hold r", int'(bus.Resto), 1);
    check("7/2 hold pronto", int'(bus.Pronto), 1);

    do_start(8'd255, 8'd1);
    check("255/1 ocupado", int'(bus.Ocupado), 1);
    check("255/1 pronto low", int'(bus.Pronto), 0);
    run_div("255/1", 8'd255, 8'd1, 255, 0, 0);
    run_div("5/9", 8'd5, 8'd9, 0, 5, 0);
    run_div("100/0", 8'd100, 8'd0, 255, 100, 1);
    run_div("9/3", 8'd9, 8'd3, 3, 0, 0);
    run_div("200/7", 8'd200, 8'd7, 28, 4, 0);

    // Restart mid-calculation
    do_start(8'd200, 8'd3);
`ifdef DIVISOR_RAPIDO_EN
    for (int i = 0; i < 5; i++) begin
`else
    for (int i = 0; i < 10; i++) begin
`endif
      check("restart no pronto", int'(bus.Pronto), 0);
      @(posedge CLOCK);
      #1;
    end
    run_div("50/7 restart", 8'd50, 8'd7, 7, 1, 0);

    // Reset mid-calculation
    do_start(8'd200, 8'd3);
    repeat (4) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    check("midrst quociente", int'(bus.Quociente), 0);
    check("midrst resto", int'(bus.Resto), 0);
    check("midrst ocupado", int'(bus.Ocupado), 0);
    check("midrst pronto", int'(bus.Pronto), 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    repeat (10) @(posedge CLOCK);
    #1;
    check("midrst idle pronto", int'(bus.Pronto), 0);
    check("midrst idle ocupado", int'(bus.Ocupado), 0);
    run_div("13/4 after rst", 8'd13, 8'd4, 3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
